id_exe_stage: RTL

- Pipeline boundary between the decode/control stage and the execute stage of the 5-stage ARM core.
- Registers decoded control (exe_cmd, mem_read, mem_write, WB_en, branch, S) and operands from ID, with per-stage valid tracking.
- Handles three pipeline actions: freeze (stall), flush (taken branch) and hazard bubble insertion.
- Owns the NZCV status register updated from the execute ALU, plus saturating bubble/flush event counters for debug.

---
 rtl/id_exe_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/id_exe_stage.sv
// ID->EXE pipeline register with freeze/flush/bubble handling, the NZCV status
// register, and saturating debug counters for bubbles and flushes.
module id_exe_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             hazard,
  input  logic             id_valid,
  input  logic [DW-1:0]    id_pc,
  input  logic [DW-1:0]    id_val_rn,
  input  logic [DW-1:0]    id_val_rm,
  input  logic             id_imm,
  input  logic [11:0]      id_shift_operand,
  input  logic [23:0]      id_signed_imm_24,
  input  logic [3:0]       id_dest,
  input  logic [3:0]       id_exe_cmd,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_wb_en,
  input  logic             id_branch,
  input  logic             id_s,
  input  logic [3:0]       alu_status,
  input  logic             cnt_clr,
  output logic             exe_valid,
  output logic [DW-1:0]    exe_pc,
  output logic [DW-1:0]    exe_val_rn,
  output logic [DW-1:0]    exe_val_rm,
  output logic             exe_imm,
  output logic [11:0]      exe_shift_operand,
  output logic [23:0]      exe_signed_imm_24,
  output logic [3:0]       exe_dest,
  output logic [3:0]       exe_exe_cmd,
  output logic             exe_mem_read,
  output logic             exe_mem_write,
  output logic             exe_wb_en,
  output logic             exe_branch,
  output logic             exe_s,
  output logic [3:0]       sr,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_valid;
  logic [DW-1:0]    r_pc, r_val_rn, r_val_rm;
  logic             r_imm;
  logic [11:0]      r_shift_operand;
  logic [23:0]      r_signed_imm_24;
  logic [3:0]       r_dest, r_exe_cmd;
  logic             r_mem_read, r_mem_write, r_wb_en, r_branch, r_s;
  logic [3:0]       r_sr;
  logic [CNT_W-1:0] r_bubble_cnt, r_flush_cnt;

  logic w_kill;
  logic w_ctrl_en;

  assign w_kill    = flush | hazard;
  // Controls only pass through for a real, unkilled instruction.
  assign w_ctrl_en = id_valid & ~w_kill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid         <= 1'b0;
      r_pc            <= '0;
      r_val_rn        <= '0;
      r_val_rm        <= '0;
      r_imm           <= 1'b0;
      r_shift_operand <= '0;
      r_signed_imm_24 <= '0;
      r_dest          <= '0;
      r_exe_cmd       <= '0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_wb_en         <= 1'b0;
      r_branch        <= 1'b0;
      r_s             <= 1'b0;
    end else if (!freeze) begin
      r_valid         <= w_ctrl_en;
      r_pc            <= w_kill ? '0 : id_pc;
      r_val_rn        <= w_kill ? '0 : id_val_rn;
      r_val_rm        <= w_kill ? '0 : id_val_rm;
      r_imm           <= w_kill ? 1'b0 : id_imm;
      r_shift_operand <= w_kill ? '0 : id_shift_operand;
      r_signed_imm_24 <= w_kill ? '0 : id_signed_imm_24;
      r_dest          <= w_kill ? '0 : id_dest;
      r_exe_cmd       <= w_ctrl_en ? id_exe_cmd : '0;
      r_mem_read      <= w_ctrl_en & id_mem_read;
      r_mem_write     <= w_ctrl_en & id_mem_write;
      r_wb_en         <= w_ctrl_en & id_wb_en;
      r_branch        <= w_ctrl_en & id_branch;
      r_s             <= w_ctrl_en & id_s;
    end
  end

  // Flags follow the instruction currently in EXE, even on a flush edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else if (!freeze && r_valid && r_s) begin
      r_sr <= alu_status;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (!freeze) begin
      if (cnt_clr) begin
        r_bubble_cnt <= '0;
        r_flush_cnt  <= '0;
      end else if (flush) begin
        if (r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end else if (hazard) begin
        if (r_bubble_cnt != CNT_MAX) r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
    end
  end

  assign exe_valid         = r_valid;
  assign exe_pc            = r_pc;
  assign exe_val_rn        = r_val_rn;
  assign exe_val_rm        = r_val_rm;
  assign exe_imm           = r_imm;
  assign exe_shift_operand = r_shift_operand;
  assign exe_signed_imm_24 = r_signed_imm_24;
  assign exe_dest          = r_dest;
  assign exe_exe_cmd       = r_exe_cmd;
  assign exe_mem_read      = r_mem_read;
  assign exe_mem_write     = r_mem_write;
  assign exe_wb_en         = r_wb_en;
  assign exe_branch        = r_branch;
  assign exe_s             = r_s;
  assign sr                = r_sr;
  assign bubble_cnt        = r_bubble_cnt;
  assign flush_cnt         = r_flush_cnt;

endmodule
